// File: rtl/mem_access_unit.sv
// Memory stage of the MiniRiscV datapath. It runs a single load or store against a
// variable-latency data memory and reports completion with done/fault status.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           ReadData2,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fault,
    output logic [31:0]           LoadData,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_TMO   = 2'b10;
    localparam logic [1:0] FLT_ILL   = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [2:0]            f3_q, f3_nxt;
    logic [1:0]            off_q, off_nxt;
    logic                  is_load_q, is_load_nxt;
    logic                  busy_nxt, done_nxt, mem_en_nxt;
    logic [1:0]            fault_nxt;
    logic [31:0]           load_nxt, mem_wdata_nxt, load_ext;
    logic [3:0]            mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic                  illegal, misaligned;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^ALUResult[31:ADDR_WIDTH+2];

    // Request screening on the live inputs; only meaningful while IDLE sees start.
    always_comb begin
        illegal    = (MemRead && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) ||
                     (MemWrite && (funct3 > 3'd2));
        misaligned = (funct3[1:0] == 2'd1 && ALUResult[0]) ||
                     (funct3[1:0] == 2'd2 && ALUResult[1:0] != 2'd0);
    end

    // Lane extraction and extension of the returned word for the latched load.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'd0, rd_byte};
            3'd5:    load_ext = {16'd0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        f3_nxt        = f3_q;
        off_nxt       = off_q;
        is_load_nxt   = is_load_q;
        fault_nxt     = fault;
        load_nxt      = LoadData;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;

        case (state)
            IDLE: begin
                if (start) begin
                    f3_nxt      = funct3;
                    off_nxt     = ALUResult[1:0];
                    is_load_nxt = MemRead;
                    if (MemRead && MemWrite) begin
                        state_nxt = DONE;
                        fault_nxt = FLT_ILL;
                    end else if (!MemRead && !MemWrite) begin
                        state_nxt = DONE;
                        fault_nxt = FLT_OK;
                    end else if (illegal) begin
                        state_nxt = DONE;
                        fault_nxt = FLT_ILL;
                    end else if (misaligned) begin
                        state_nxt = DONE;
                        fault_nxt = FLT_ALIGN;
                    end else begin
                        state_nxt    = REQ;
                        cnt_nxt      = '0;
                        mem_addr_nxt = ALUResult[ADDR_WIDTH+1:2];
                        mem_we_nxt   = 4'b0000;
                        if (MemWrite) begin
                            case (funct3[1:0])
                                2'd0: begin
                                    mem_we_nxt    = 4'b0001 << ALUResult[1:0];
                                    mem_wdata_nxt = {4{ReadData2[7:0]}};
                                end
                                2'd1: begin
                                    mem_we_nxt    = 4'b0011 << ALUResult[1:0];
                                    mem_wdata_nxt = {2{ReadData2[15:0]}};
                                end
                                default: begin
                                    mem_we_nxt    = 4'b1111;
                                    mem_wdata_nxt = ReadData2;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ, WAIT: begin
                // Timeout wins over a simultaneous ready so the abort is deterministic.
                if (cnt == CNT_W'(TIMEOUT)) begin
                    state_nxt  = DONE;
                    fault_nxt  = FLT_TMO;
                    mem_we_nxt = 4'b0000;
                end else if (mem_ready) begin
                    state_nxt  = DONE;
                    fault_nxt  = FLT_OK;
                    mem_we_nxt = 4'b0000;
                    if (is_load_q) begin
                        load_nxt = load_ext;
                    end
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt   = (state_nxt != IDLE);
        done_nxt   = (state_nxt == DONE);
        mem_en_nxt = (state_nxt == REQ) || (state_nxt == WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            is_load_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= FLT_OK;
            LoadData  <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            f3_q      <= f3_nxt;
            off_q     <= off_nxt;
            is_load_q <= is_load_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            fault     <= fault_nxt;
            LoadData  <= load_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

endmodule
